// File: rtl/cnn_frame_sched.sv
// Frame-level scheduler for the CNN line-buffer pipeline: VSync-aligned frame start,
// config shadowing, pixel-count frame end, continuous/abort modes and a stall watchdog.
module cnn_frame_sched #(
  parameter int WIDTH   = 480,
  parameter int HEIGHT  = 272,
  parameter int DEPTH   = WIDTH * HEIGHT,
  parameter int TIMEOUT = 1 << 20
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEn,
  input  logic [2:0]  iCtrl,
  input  logic [31:0] iCfg0,
  input  logic [31:0] iCfg1,
  input  logic [31:0] iCfg2,
  input  logic [31:0] iCfg3,
  input  logic        iLcdVSync,
  input  logic        iOutValid,
  output logic        oRunEn,
  output logic        oPipeClr,
  output logic [31:0] oCfg0,
  output logic [31:0] oCfg1,
  output logic [31:0] oCfg2,
  output logic [31:0] oCfg3,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr,
  output logic [15:0] oFrameCnt,
  output logic [2:0]  oState
);

  localparam int PixW = $clog2(DEPTH);
  localparam int WdW  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } StateT;

  StateT            state;
  logic             startPrev;
  logic             vsyncPrev;
  logic [PixW-1:0]  pixCnt;
  logic [WdW-1:0]   wdCnt;
  logic             startEdge;
  logic             vsyncFall;
  logic             abortReq;
  logic             contMode;

  assign startEdge = iCtrl[0] & ~startPrev;
  assign vsyncFall = vsyncPrev & ~iLcdVSync;
  assign abortReq  = iCtrl[2];
  assign contMode  = iCtrl[1];

  assign oState = state;
  assign oBusy  = (state != IDLE);

  // The first RUN cycle carries the pipeline clear, so the datapath enable follows one cycle later.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      startPrev <= 1'b0;
      vsyncPrev <= 1'b0;
      pixCnt    <= '0;
      wdCnt     <= '0;
      oRunEn    <= 1'b0;
      oPipeClr  <= 1'b0;
      oDone     <= 1'b0;
      oErr      <= 1'b0;
      oFrameCnt <= '0;
      oCfg0     <= '0;
      oCfg1     <= '0;
      oCfg2     <= '0;
      oCfg3     <= '0;
    end else if (iEn) begin
      startPrev <= iCtrl[0];
      vsyncPrev <= iLcdVSync;
      oPipeClr  <= 1'b0;
      oDone     <= 1'b0;
      oRunEn    <= 1'b0;
      case (state)
        IDLE: begin
          if (startEdge && !abortReq) begin
            state <= ARM;
            oErr  <= 1'b0;
          end
        end
        ARM: begin
          if (abortReq) begin
            state <= IDLE;
          end else if (vsyncFall) begin
            oCfg0    <= iCfg0;
            oCfg1    <= iCfg1;
            oCfg2    <= iCfg2;
            oCfg3    <= iCfg3;
            oPipeClr <= 1'b1;
            pixCnt   <= '0;
            wdCnt    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abortReq) begin
            oPipeClr <= 1'b1;
            state    <= FLUSH;
          end else if (iOutValid) begin
            wdCnt <= '0;
            if (pixCnt == PixW'(DEPTH - 1)) begin
              oDone     <= 1'b1;
              oFrameCnt <= oFrameCnt + 16'd1;
              state     <= DONE;
            end else begin
              pixCnt <= pixCnt + PixW'(1);
              oRunEn <= 1'b1;
            end
          end else if (wdCnt == WdW'(TIMEOUT - 1)) begin
            oErr     <= 1'b1;
            oPipeClr <= 1'b1;
            state    <= FLUSH;
          end else begin
            wdCnt  <= wdCnt + WdW'(1);
            oRunEn <= 1'b1;
          end
        end
        FLUSH: begin
          state <= IDLE;
        end
        DONE: begin
          state <= (contMode && !abortReq) ? ARM : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_sched.sv
// Self-checking bench for cnn_frame_sched: directed scenarios with literal anchors plus
// randomized traffic, all checked against a frame-level behavioural model every clock.
module tb_cnn_frame_sched;

  localparam int Depth   = 32;
  localparam int Timeout = 64;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEn;
  logic [2:0]  iCtrl;
  logic [31:0] iCfg0, iCfg1, iCfg2, iCfg3;
  logic        iLcdVSync;
  logic        iOutValid;
  logic        oRunEn, oPipeClr, oBusy, oDone, oErr;
  logic [31:0] oCfg0, oCfg1, oCfg2, oCfg3;
  logic [15:0] oFrameCnt;
  logic [2:0]  oState;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: frame phase, counts of pixels and idle RUN cycles, expected outputs
  int          mPhase;
  int          mPix;
  int          mIdle;
  logic        mRunEn, mClr, mDone, mErr;
  logic [15:0] mFrames;
  logic [31:0] mCfg [4];
  logic        mStartPrev, mVsPrev;

  cnn_frame_sched #(.WIDTH(8), .HEIGHT(4), .DEPTH(Depth), .TIMEOUT(Timeout)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iCtrl(iCtrl),
    .iCfg0(iCfg0), .iCfg1(iCfg1), .iCfg2(iCfg2), .iCfg3(iCfg3),
    .iLcdVSync(iLcdVSync), .iOutValid(iOutValid),
    .oRunEn(oRunEn), .oPipeClr(oPipeClr),
    .oCfg0(oCfg0), .oCfg1(oCfg1), .oCfg2(oCfg2), .oCfg3(oCfg3),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oFrameCnt(oFrameCnt), .oState(oState)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mPix = 0; mIdle = 0;
    mRunEn = 0; mClr = 0; mDone = 0; mErr = 0; mFrames = '0;
    for (int i = 0; i < 4; i++) mCfg[i] = '0;
    mStartPrev = 0; mVsPrev = 0;
  endtask

  // One enabled edge of the frame-level rules, evaluated on the inputs seen at that edge
  task automatic modelEdge();
    logic startEdge, vsFall, abortReq, contMode, nClr, nDone;
    startEdge = iCtrl[0] & ~mStartPrev;
    vsFall    = mVsPrev & ~iLcdVSync;
    abortReq  = iCtrl[2];
    contMode  = iCtrl[1];
    nClr = 0; nDone = 0;
    case (mPhase)
      0: if (startEdge && !abortReq) begin mPhase = 1; mErr = 0; end
      1: if (abortReq) mPhase = 0;
         else if (vsFall) begin
           mCfg[0] = iCfg0; mCfg[1] = iCfg1; mCfg[2] = iCfg2; mCfg[3] = iCfg3;
           nClr = 1; mPix = 0; mIdle = 0; mPhase = 2;
         end
      2: if (abortReq) begin mPhase = 3; nClr = 1; end
         else if (iOutValid) begin
           mPix++; mIdle = 0;
           if (mPix == Depth) begin mPhase = 4; nDone = 1; mFrames = mFrames + 16'd1; end
         end else begin
           mIdle++;
           if (mIdle == Timeout) begin mErr = 1; mPhase = 3; nClr = 1; end
         end
      3: mPhase = 0;
      default: mPhase = (contMode && !abortReq) ? 1 : 0;
    endcase
    mClr   = nClr;
    mDone  = nDone;
    mRunEn = (mPhase == 2) && !nClr;
    mStartPrev = iCtrl[0];
    mVsPrev    = iLcdVSync;
  endtask

  task automatic checkOutput();
    check("state", 32'(oState), 32'(mPhase));
    check("busy", 32'(oBusy), 32'(mPhase != 0));
    check("runEn", 32'(oRunEn), 32'(mRunEn));
    check("pipeClr", 32'(oPipeClr), 32'(mClr));
    check("done", 32'(oDone), 32'(mDone));
    check("err", 32'(oErr), 32'(mErr));
    check("frameCnt", 32'(oFrameCnt), 32'(mFrames));
    check("cfg0", oCfg0, mCfg[0]);
    check("cfg1", oCfg1, mCfg[1]);
    check("cfg2", oCfg2, mCfg[2]);
    check("cfg3", oCfg3, mCfg[3]);
    if (oRunEn && oPipeClr) check("runEnClrExclusive", 32'd1, 32'd0);
  endtask

  // One iEn cycle: enabled edge, then three disabled clocks during which everything must hold
  task automatic applyStimulus();
    iEn = 1'b1;
    @(posedge iClk);
    modelEdge();
    #1;
    iEn = 1'b0;
    checkOutput();
    for (int k = 0; k < 3; k++) begin
      @(posedge iClk);
      #1;
      checkOutput();
    end
  endtask

  task automatic doReset();
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    modelReset();
    checkOutput();
  endtask

  task automatic startAndRun(input logic [2:0] ctrl, input logic [31:0] cfg0);
    iCtrl = 3'b000; iOutValid = 1'b0; applyStimulus();
    iCtrl = ctrl; applyStimulus();
    iLcdVSync = 1'b1; applyStimulus();
    iLcdVSync = 1'b0; iCfg0 = cfg0; applyStimulus();
  endtask

  task automatic pixels(input int n);
    iOutValid = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus();
    iOutValid = 1'b0;
  endtask

  initial begin
    iRst = 1'b0; iEn = 1'b0; iCtrl = '0; iLcdVSync = 1'b0; iOutValid = 1'b0;
    iCfg0 = '0; iCfg1 = 32'h11; iCfg2 = 32'h22; iCfg3 = 32'h33;
    modelReset();
    repeat (2) @(posedge iClk);
    #1;
    doReset();
    check("resetState", 32'(oState), 32'd0);

    // Reset in the middle of a frame
    startAndRun(3'b001, 32'hAAAA);
    pixels(3);
    doReset();
    check("midRunResetState", 32'(oState), 32'd0);
    check("midRunResetRunEn", 32'(oRunEn), 32'd0);
    check("midRunResetCfg0", oCfg0, 32'h0);
    check("midRunResetFrames", 32'(oFrameCnt), 32'd0);

    // Single shot
    startAndRun(3'b001, 32'h1234);
    check("ssPipeClr", 32'(oPipeClr), 32'd1);
    check("ssCfg0", oCfg0, 32'h1234);
    iCfg0 = 32'h0; applyStimulus();
    check("ssRunEn", 32'(oRunEn), 32'd1);
    pixels(Depth);
    check("ssDone", 32'(oDone), 32'd1);
    check("ssFrames", 32'(oFrameCnt), 32'd1);
    applyStimulus();
    check("ssIdle", 32'(oState), 32'd0);

    // Continuous: config only reshadows at each frame start
    startAndRun(3'b011, 32'h1234);
    pixels(10);
    iCfg0 = 32'hBEEF;
    pixels(Depth - 10);
    check("contFrame1Cfg", oCfg0, 32'h1234);
    check("contFrames2", 32'(oFrameCnt), 32'd2);
    applyStimulus();
    check("contRearm", 32'(oState), 32'd1);
    iLcdVSync = 1'b1; applyStimulus();
    iLcdVSync = 1'b0; applyStimulus();
    check("contFrame2Cfg", oCfg0, 32'hBEEF);
    iCtrl = 3'b001;
    pixels(Depth);
    check("contFrames3", 32'(oFrameCnt), 32'd3);
    applyStimulus();

    // Abort at pixel 10, then abort colliding with the last pixel
    startAndRun(3'b001, 32'h5555);
    pixels(10);
    iCtrl = 3'b100; applyStimulus();
    check("abortFlush", 32'(oState), 32'd3);
    check("abortClr", 32'(oPipeClr), 32'd1);
    iCtrl = 3'b000; applyStimulus();
    check("abortIdle", 32'(oState), 32'd0);
    startAndRun(3'b001, 32'h6666);
    pixels(Depth - 1);
    iCtrl = 3'b100; iOutValid = 1'b1; applyStimulus();
    iOutValid = 1'b0; iCtrl = 3'b000;
    check("abortLastFlush", 32'(oState), 32'd3);
    check("abortLastFrames", 32'(oFrameCnt), 32'd3);
    applyStimulus();

    // Watchdog
    startAndRun(3'b001, 32'h7777);
    for (int i = 0; i < Timeout - 1; i++) applyStimulus();
    check("wdNotYet", 32'(oErr), 32'd0);
    applyStimulus();
    check("wdErr", 32'(oErr), 32'd1);
    check("wdFlush", 32'(oState), 32'd3);
    applyStimulus();
    check("wdIdleSticky", 32'(oErr), 32'd1);
    iCtrl = 3'b000; applyStimulus();
    iCtrl = 3'b001; applyStimulus();
    check("wdErrCleared", 32'(oErr), 32'd0);

    // Start edge during RUN is ignored
    iLcdVSync = 1'b1; applyStimulus();
    iLcdVSync = 1'b0; applyStimulus();
    pixels(5);
    iCtrl = 3'b000; applyStimulus();
    iCtrl = 3'b001; applyStimulus();
    check("startInRun", 32'(oState), 32'd2);
    pixels(Depth);
    applyStimulus();

    // Randomized traffic with occasional stalls and resets
    for (int n = 0; n < 2500; n++) begin
      iCtrl[0]  = ($urandom_range(0, 7) == 0);
      iCtrl[1]  = $urandom_range(0, 1) == 1;
      iCtrl[2]  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 5) == 0) iLcdVSync = ~iLcdVSync;
      iOutValid = ((n % 600) < 520) && ($urandom_range(0, 3) != 0);
      iCfg0 = $urandom; iCfg1 = $urandom; iCfg2 = $urandom; iCfg3 = $urandom;
      if ($urandom_range(0, 999) == 0) doReset();
      else applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
